// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Purpose: shares one line-wide memory port between NUM_PORTS requesters.
// One transaction is outstanding at a time.  A winner is picked in IDLE
// (fixed priority or round-robin).  Its address, write line and operation
// are captured, and the memory is driven only from those captured copies
// until pmem_resp.  Each completion is followed by one IDLE cycle.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   port_read       - per-port line-read request
//   port_write      - per-port line-write request (wins over read)
//   port_addr       - per-port address, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   port_wdata      - per-port write line, packed the same way
//   port_resp       - per-port completion pulse (granted port only)
//   port_rdata      - pmem_rdata broadcast to every port
//   pmem_read       - memory read strobe
//   pmem_write      - memory write strobe
//   pmem_address    - memory address
//   pmem_wdata      - memory write line
//   pmem_rdata      - memory read line
//   pmem_resp       - memory completion
//   grant           - index of the granted port, valid while busy
//   busy            - a memory transaction is outstanding
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32,
    parameter int RR_MODE    = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            port_read,
    input  logic [NUM_PORTS-1:0]            port_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] port_addr,
    input  logic [NUM_PORTS*LINE_WIDTH-1:0] port_wdata,
    output logic [NUM_PORTS-1:0]            port_resp,
    output logic [LINE_WIDTH-1:0]           port_rdata,
    output logic                            pmem_read,
    output logic                            pmem_write,
    output logic [ADDR_WIDTH-1:0]           pmem_address,
    output logic [LINE_WIDTH-1:0]           pmem_wdata,
    input  logic [LINE_WIDTH-1:0]           pmem_rdata,
    input  logic                            pmem_resp,
    output logic [$clog2(NUM_PORTS)-1:0]    grant,
    output logic                            busy
);

    localparam int GW = $clog2(NUM_PORTS);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_nextState;

    logic [GW-1:0]          r_grant;
    logic [GW-1:0]          r_ptr;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [LINE_WIDTH-1:0]  r_wdata;
    logic                   r_isWrite;

    logic [NUM_PORTS-1:0]   w_req;
    logic [NUM_PORTS-1:0]   w_hiMask;
    logic [NUM_PORTS-1:0]   w_hiReq;
    logic                   w_anyReq;
    logic [GW-1:0]          w_winner;
    logic                   w_capture;

    // Lowest set bit of a request vector; 0 when the vector is empty.
    function automatic logic [GW-1:0] lowestIndex(input logic [NUM_PORTS-1:0] v);
        logic [GW-1:0] idx;
        idx = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (v[i]) idx = GW'(i);
        end
        return idx;
    endfunction

    assign w_req     = port_read | port_write;
    assign w_anyReq  = |w_req;
    assign w_capture = (r_state == IDLE) && w_anyReq;

    // Ports at or above the rotation pointer form the preferred group.
    always_comb begin
        w_hiMask = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_hiMask[i] = (i >= int'(r_ptr));
        end
    end

    assign w_hiReq = w_req & w_hiMask;

    // Round-robin: lowest requester in the preferred group, otherwise the
    // search has wrapped and the lowest requester overall wins.
    always_comb begin
        if (RR_MODE == 0)
            w_winner = lowestIndex(w_req);
        else if (|w_hiReq)
            w_winner = lowestIndex(w_hiReq);
        else
            w_winner = lowestIndex(w_req);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_nextState;
    end

    // Next-state logic.  A pmem_resp in IDLE is ignored.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_anyReq)  w_nextState = BUSY;
            BUSY:    if (pmem_resp) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Request capture at grant time.  The rotation pointer advances past
    // the granted port only when its transaction completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant   <= '0;
            r_ptr     <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_isWrite <= 1'b0;
        end else if (w_capture) begin
            r_grant   <= w_winner;
            r_addr    <= port_addr[int'(w_winner)*ADDR_WIDTH +: ADDR_WIDTH];
            r_wdata   <= port_wdata[int'(w_winner)*LINE_WIDTH +: LINE_WIDTH];
            r_isWrite <= port_write[w_winner];
        end else if ((r_state == BUSY) && pmem_resp) begin
            r_ptr <= (r_grant == GW'(NUM_PORTS - 1)) ? '0 : r_grant + 1'b1;
        end
    end

    // Output logic.  The memory side sees only the captured copies, and is
    // held at zero outside a transaction.
    always_comb begin
        busy         = (r_state == BUSY);
        grant        = r_grant;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        port_resp    = '0;
        if (r_state == BUSY) begin
            pmem_read          = ~r_isWrite;
            pmem_write         = r_isWrite;
            pmem_address       = r_addr;
            pmem_wdata         = r_wdata;
            port_resp[r_grant] = pmem_resp;
        end
    end

    assign port_rdata = pmem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Drives a fixed-priority and a round-robin arbiter (4 ports each) from the
// same inputs.  Both are compared every cycle against a transaction-level
// reference model.  Directed sequences come first, then randomized traffic.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int N  = 4;
    localparam int LW = 64;
    localparam int AW = 32;
    localparam int GW = $clog2(N);

    logic              clk;
    logic              rst;
    logic [N-1:0]      portRead;
    logic [N-1:0]      portWrite;
    logic [N*AW-1:0]   portAddr;
    logic [N*LW-1:0]   portWdata;
    logic [LW-1:0]     pmemRdata;
    logic              pmemResp;

    logic [N-1:0]      respO  [2];
    logic [LW-1:0]     rdataO [2];
    logic              pRdO   [2];
    logic              pWrO   [2];
    logic [AW-1:0]     pAddrO [2];
    logic [LW-1:0]     pWdO   [2];
    logic [GW-1:0]     grantO [2];
    logic              busyO  [2];

    // Reference model state, index 0 = fixed priority, 1 = round-robin.
    bit                mBusy  [2];
    int                mGrant [2];
    int                mPtr   [2];
    logic [AW-1:0]     mAddr  [2];
    logic [LW-1:0]     mData  [2];
    bit                mWrite [2];

    int checkCount = 0;
    int errorCount = 0;

    mem_arbiter #(.NUM_PORTS(N), .LINE_WIDTH(LW), .ADDR_WIDTH(AW), .RR_MODE(0)) dutFp (
        .clk(clk), .rst(rst),
        .port_read(portRead), .port_write(portWrite),
        .port_addr(portAddr), .port_wdata(portWdata),
        .port_resp(respO[0]), .port_rdata(rdataO[0]),
        .pmem_read(pRdO[0]), .pmem_write(pWrO[0]),
        .pmem_address(pAddrO[0]), .pmem_wdata(pWdO[0]),
        .pmem_rdata(pmemRdata), .pmem_resp(pmemResp),
        .grant(grantO[0]), .busy(busyO[0])
    );

    mem_arbiter #(.NUM_PORTS(N), .LINE_WIDTH(LW), .ADDR_WIDTH(AW), .RR_MODE(1)) dutRr (
        .clk(clk), .rst(rst),
        .port_read(portRead), .port_write(portWrite),
        .port_addr(portAddr), .port_wdata(portWdata),
        .port_resp(respO[1]), .port_rdata(rdataO[1]),
        .pmem_read(pRdO[1]), .pmem_write(pWrO[1]),
        .pmem_address(pAddrO[1]), .pmem_wdata(pWdO[1]),
        .pmem_rdata(pmemRdata), .pmem_resp(pmemResp),
        .grant(grantO[1]), .busy(busyO[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports.
    task automatic checkOutput(input string tag, input logic [LW-1:0] observed,
                               input logic [LW-1:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Winner by the arbitration rule: scan upward from the pointer with wrap
    // (the pointer is 0 for fixed priority).
    function automatic int pickWinner(input logic [N-1:0] req, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (req[(ptr + k) % N]) return (ptr + k) % N;
        end
        return 0;
    endfunction

    // Advance the model by one clock edge using the inputs now driven.
    task automatic modelStep();
        logic [N-1:0] req;
        int w;
        req = portRead | portWrite;
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                mBusy[m]  = 1'b0;
                mGrant[m] = 0;
                mPtr[m]   = 0;
                mAddr[m]  = '0;
                mData[m]  = '0;
                mWrite[m] = 1'b0;
            end else if (!mBusy[m]) begin
                if (req != '0) begin
                    w         = pickWinner(req, (m == 1) ? mPtr[m] : 0);
                    mBusy[m]  = 1'b1;
                    mGrant[m] = w;
                    mAddr[m]  = portAddr[w*AW +: AW];
                    mData[m]  = portWdata[w*LW +: LW];
                    mWrite[m] = portWrite[w];
                end
            end else if (pmemResp) begin
                mBusy[m] = 1'b0;
                mPtr[m]  = (mGrant[m] + 1) % N;
            end
        end
    endtask

    // Compare every output of both arbiters with the model.
    task automatic checkAll();
        logic [N-1:0] expResp;
        for (int m = 0; m < 2; m++) begin
            expResp = '0;
            if (mBusy[m] && pmemResp) expResp[mGrant[m]] = 1'b1;
            checkOutput($sformatf("busy[%0d]", m), LW'(busyO[m]), LW'(mBusy[m]));
            if (mBusy[m])
                checkOutput($sformatf("grant[%0d]", m), LW'(grantO[m]), LW'(mGrant[m]));
            checkOutput($sformatf("pmemRead[%0d]", m), LW'(pRdO[m]), LW'(mBusy[m] & ~mWrite[m]));
            checkOutput($sformatf("pmemWrite[%0d]", m), LW'(pWrO[m]), LW'(mBusy[m] & mWrite[m]));
            checkOutput($sformatf("pmemAddr[%0d]", m), LW'(pAddrO[m]), mBusy[m] ? LW'(mAddr[m]) : '0);
            checkOutput($sformatf("pmemWdata[%0d]", m), pWdO[m], mBusy[m] ? mData[m] : '0);
            checkOutput($sformatf("portResp[%0d]", m), LW'(respO[m]), LW'(expResp));
            checkOutput($sformatf("portRdata[%0d]", m), rdataO[m], pmemRdata);
        end
    endtask

    // Drive one cycle of inputs away from the rising edge, then compare.
    task automatic applyStimulus(input logic [N-1:0] rd, input logic [N-1:0] wr,
                                 input logic [N*AW-1:0] addr, input logic [N*LW-1:0] wd,
                                 input logic resp, input logic [LW-1:0] rdata,
                                 input logic rstIn);
        @(negedge clk);
        portRead  = rd;
        portWrite = wr;
        portAddr  = addr;
        portWdata = wd;
        pmemResp  = resp;
        pmemRdata = rdata;
        rst       = rstIn;
        #1;
        checkAll();
    endtask

    task automatic stepClock();
        @(posedge clk);
        modelStep();
    endtask

    function automatic logic [N*AW-1:0] randAddr();
        logic [N*AW-1:0] v;
        for (int i = 0; i < N; i++) v[i*AW +: AW] = $urandom;
        return v;
    endfunction

    function automatic logic [N*LW-1:0] randData();
        logic [N*LW-1:0] v;
        for (int i = 0; i < N; i++) v[i*LW +: LW] = {$urandom, $urandom};
        return v;
    endfunction

    function automatic logic [LW-1:0] randLine();
        return {$urandom, $urandom};
    endfunction

    initial begin
        logic [N*AW-1:0] addr;
        logic [N*LW-1:0] wd;
        int expRr [5];
        int seen;
        int busyCnt;
        logic resp;

        expRr = '{0, 1, 2, 3, 0};
        rst = 1'b1;
        portRead = '0; portWrite = '0; portAddr = '0; portWdata = '0;
        pmemResp = 1'b0; pmemRdata = '0;

        // Reset: every output is zero afterwards.
        applyStimulus('0, '0, '0, '0, 1'b0, '0, 1'b1); stepClock();
        applyStimulus('0, '0, '0, '0, 1'b0, '0, 1'b1); stepClock();
        applyStimulus('0, '0, '0, '0, 1'b0, '0, 1'b0);
        for (int m = 0; m < 2; m++) begin
            checkOutput("rstGrant", LW'(grantO[m]), '0);
            checkOutput("rstBusy", LW'(busyO[m]), '0);
            checkOutput("rstResp", LW'(respO[m]), '0);
        end
        stepClock();

        // Single read from port 1 at 0x100, response after three busy cycles.
        addr = '0;
        addr[1*AW +: AW] = 32'h100;
        applyStimulus(4'b0010, '0, addr, '0, 1'b0, '0, 1'b0); stepClock();
        for (int c = 0; c < 4; c++) begin
            applyStimulus('0, '0, randAddr(), randData(), (c == 3), randLine(), 1'b0);
            for (int m = 0; m < 2; m++) begin
                if (c == 0) begin
                    checkOutput("singleRead", LW'(pRdO[m]), LW'(1'b1));
                    checkOutput("singleAddr", LW'(pAddrO[m]), LW'(32'h100));
                    checkOutput("singleGrant", LW'(grantO[m]), LW'(1));
                end
                if (c == 3) checkOutput("singleResp", LW'(respO[m]), LW'(4'b0010));
            end
            stepClock();
        end
        applyStimulus('0, '0, '0, '0, 1'b0, '0, 1'b0);
        for (int m = 0; m < 2; m++) checkOutput("singleDone", LW'(busyO[m]), '0);
        stepClock();

        // All ports reading continuously, response two cycles after strobe.
        applyStimulus('0, '0, '0, '0, 1'b0, '0, 1'b1); stepClock();
        seen = 0;
        busyCnt = 0;
        for (int cyc = 0; cyc < 100 && seen < 5; cyc++) begin
            if (mBusy[1]) begin
                resp = (busyCnt == 2);
                busyCnt++;
            end else begin
                resp = 1'b0;
                busyCnt = 0;
            end
            applyStimulus('1, '0, randAddr(), randData(), resp, randLine(), 1'b0);
            if (mBusy[1] && busyCnt == 1) begin
                checkOutput($sformatf("seqRr%0d", seen), LW'(grantO[1]), LW'(expRr[seen]));
                checkOutput($sformatf("seqFp%0d", seen), LW'(grantO[0]), '0);
                seen++;
            end
            stepClock();
        end
        checkOutput("seqCount", LW'(seen), LW'(5));

        // Reset during the second busy cycle, then a late pmem_resp.
        applyStimulus('0, '0, '0, '0, 1'b0, '0, 1'b1); stepClock();
        applyStimulus(4'b0100, '0, randAddr(), randData(), 1'b0, '0, 1'b0); stepClock();
        applyStimulus('0, '0, randAddr(), randData(), 1'b0, '0, 1'b0); stepClock();
        applyStimulus('0, '0, randAddr(), randData(), 1'b0, '0, 1'b1); stepClock();
        applyStimulus('0, '0, randAddr(), randData(), 1'b1, '0, 1'b0);
        for (int m = 0; m < 2; m++) begin
            checkOutput("abortResp", LW'(respO[m]), '0);
            checkOutput("abortBusy", LW'(busyO[m]), '0);
            checkOutput("abortStrobe", LW'(pRdO[m] | pWrO[m]), '0);
        end
        stepClock();
        applyStimulus('1, '0, randAddr(), randData(), 1'b0, '0, 1'b0); stepClock();
        applyStimulus('0, '0, randAddr(), randData(), 1'b0, '0, 1'b0);
        checkOutput("abortNextGrant", LW'(grantO[1]), '0);
        stepClock();
        applyStimulus('0, '0, randAddr(), randData(), 1'b1, '0, 1'b0); stepClock();

        // Stray pmem_resp in IDLE with no requests.
        applyStimulus('0, '0, randAddr(), randData(), 1'b1, randLine(), 1'b0);
        for (int m = 0; m < 2; m++) checkOutput("strayResp", LW'(respO[m]), '0);
        stepClock();
        applyStimulus('0, '0, '0, '0, 1'b0, '0, 1'b0);
        for (int m = 0; m < 2; m++) checkOutput("strayBusy", LW'(busyO[m]), '0);
        stepClock();

        // Write capture: port 0 write at 0x40, inputs scrambled after grant.
        addr = '0;
        addr[0 +: AW] = 32'h40;
        wd = '0;
        wd[0 +: LW] = 64'hDEAD_BEEF_CAFE_F00D;
        applyStimulus(4'b0001, 4'b0001, addr, wd, 1'b0, '0, 1'b0); stepClock();
        for (int c = 0; c < 3; c++) begin
            applyStimulus($urandom, $urandom, randAddr(), randData(), (c == 2), randLine(), 1'b0);
            checkOutput("holdWrite", LW'(pWrO[0]), LW'(1'b1));
            checkOutput("holdAddr", LW'(pAddrO[0]), LW'(32'h40));
            checkOutput("holdWdata", pWdO[0], 64'hDEAD_BEEF_CAFE_F00D);
            stepClock();
        end

        // Randomized traffic.
        for (int cyc = 0; cyc < 800; cyc++) begin
            logic [N-1:0] rd;
            logic [N-1:0] wr;
            logic rr;
            for (int i = 0; i < N; i++) begin
                rd[i] = ($urandom_range(9, 0) < 3);
                wr[i] = ($urandom_range(9, 0) < 2);
            end
            resp = mBusy[1] ? ($urandom_range(99, 0) < 35) : ($urandom_range(99, 0) < 10);
            rr   = ($urandom_range(99, 0) < 2);
            applyStimulus(rd, wr, randAddr(), randData(), resp, randLine(), rr);
            stepClock();
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
